// File: rtl/exec_ctrl.sv
// ---------------------------------------------------------------------------
// exec_ctrl
//   Multi-cycle execute controller that sits in front of a 4x9 register file.
//   Accepts one instruction per valid/ready handshake, drives the register-file
//   read addresses, latches the returned operands, computes the ALU result and
//   drives the write-back port. Every instruction occupies the controller for
//   exactly four cycles: IDLE -> READ -> EXEC -> WRITE -> IDLE.
//
// Ports
//   clk          in   1   clock, all state updates on posedge
//   rst          in   1   asynchronous active-low reset
//   instr_valid  in   1   instruction offered
//   instr_ready  out  1   high only in IDLE
//   instr        in   IW  {op, dst, src0, src1}
//   ld_data      in   DW  LOAD operand, sampled at accept
//   rd0_addr     out  AW  register file read port 0 address (src0)
//   rd1_addr     out  AW  register file read port 1 address (src1)
//   rd0_data     in   DW  register file read port 0 data
//   rd1_data     in   DW  register file read port 1 data
//   wr_en        out  1   register file write enable (WRITE only)
//   wr_addr      out  AW  write-back address (dst)
//   wr_data      out  DW  registered ALU result
//   done         out  1   one-cycle pulse in WRITE
//   carry        out  1   carry/borrow flag of the last executed op
//   zero         out  1   result==0 flag of the last executed op
// ---------------------------------------------------------------------------
module exec_ctrl #(
   parameter int DW  = 9,
   parameter int AW  = 2,
   parameter int OPW = 3,
   localparam int IW = OPW + 3*AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [IW-1:0] instr,
   input  logic [DW-1:0] ld_data,
   output logic [AW-1:0] rd0_addr,
   output logic [AW-1:0] rd1_addr,
   input  logic [DW-1:0] rd0_data,
   input  logic [DW-1:0] rd1_data,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          done,
   output logic          carry,
   output logic          zero
);

   localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
   localparam logic [OPW-1:0] OP_AND  = OPW'(2);
   localparam logic [OPW-1:0] OP_OR   = OPW'(3);
   localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
   localparam logic [OPW-1:0] OP_NOT  = OPW'(5);
   localparam logic [OPW-1:0] OP_SHL  = OPW'(6);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_EXEC  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [OPW-1:0]  r_op;
   logic [AW-1:0]   r_dst;
   logic [AW-1:0]   r_src0;
   logic [AW-1:0]   r_src1;
   logic [DW-1:0]   r_ld;
   logic [DW-1:0]   r_a;
   logic [DW-1:0]   r_b;
   logic [DW-1:0]   r_result;
   logic            r_carry;
   logic            r_zero;

   logic [DW:0]     w_sum;
   logic [DW:0]     w_diff;
   logic [DW-1:0]   w_result;
   logic            w_carry;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (instr_valid) w_state_next = S_READ;
         S_READ:  w_state_next = S_EXEC;
         S_EXEC:  w_state_next = S_WRITE;
         S_WRITE: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------- ALU ----------------
   // Widened add/sub so bit DW carries the carry-out or the borrow.
   assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff = {1'b0, r_a} - {1'b0, r_b};

   always_comb begin
      w_result = '0;
      w_carry  = 1'b0;
      case (r_op)
         OP_ADD:  begin w_result = w_sum[DW-1:0];  w_carry = w_sum[DW];  end
         OP_SUB:  begin w_result = w_diff[DW-1:0]; w_carry = w_diff[DW]; end
         OP_AND:  w_result = r_a & r_b;
         OP_OR:   w_result = r_a | r_b;
         OP_XOR:  w_result = r_a ^ r_b;
         OP_NOT:  w_result = ~r_a;
         OP_SHL:  begin w_result = {r_a[DW-2:0], 1'b0}; w_carry = r_a[DW-1]; end
         default: w_result = r_ld;   // LOAD ignores the operands
      endcase
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op     <= '0;
         r_dst    <= '0;
         r_src0   <= '0;
         r_src1   <= '0;
         r_ld     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (instr_valid) begin
                  r_op   <= instr[IW-1 -: OPW];
                  r_dst  <= instr[3*AW-1 -: AW];
                  r_src0 <= instr[2*AW-1 -: AW];
                  r_src1 <= instr[AW-1:0];
                  r_ld   <= ld_data;
               end
            end
            S_READ: begin
               // Register file refreshed its read data on the negedge of READ.
               r_a <= rd0_data;
               r_b <= rd1_data;
            end
            S_EXEC: begin
               r_result <= w_result;
               r_carry  <= w_carry;
               r_zero   <= (w_result == '0);
            end
            default: ;
         endcase
      end
   end

   // Outputs decode straight from the state so an async reset drops wr_en/done at once.
   assign instr_ready = (r_state == S_IDLE);
   assign wr_en       = (r_state == S_WRITE);
   assign done        = (r_state == S_WRITE);
   assign rd0_addr    = r_src0;
   assign rd1_addr    = r_src1;
   assign wr_addr     = r_dst;
   assign wr_data     = r_result;
   assign carry       = r_carry;
   assign zero        = r_zero;

endmodule

// File: tb/tb_exec_ctrl.sv
module tb_exec_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [8:0] instr;
   logic [8:0] ld_data;
   logic [1:0] rd0_addr, rd1_addr;
   logic [8:0] rd0_data, rd1_data;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [8:0] wr_data;
   logic       done, carry, zero;

   exec_ctrl dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .ld_data(ld_data),
      .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
      .rd0_data(rd0_data), .rd1_data(rd1_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .done(done), .carry(carry), .zero(zero)
   );

   always #5 clk = ~clk;

   // Register file model: write at negedge when wr_en, otherwise refresh reads.
   logic [8:0] rf [4];
   initial begin
      for (int i = 0; i < 4; i++) rf[i] = '0;
      rd0_data = '0;
      rd1_data = '0;
   end
   always @(negedge clk) begin
      if (wr_en) rf[wr_addr] <= wr_data;
      else begin
         rd0_data <= rf[rd0_addr];
         rd1_data <= rf[rd1_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      logic [2:0] op;
      logic [1:0] dst, s0, s1;
      logic [8:0] ld;
      logic [8:0] exp_d;
      logic       exp_c, exp_z;
   } vec_t;

   typedef struct {
      logic [1:0] addr;
      logic [8:0] data;
      logic       c, z;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   bit   mon_en = 1'b0;

   function automatic vec_t mk(input logic [2:0] op, input logic [1:0] dst, s0, s1,
                               input logic [8:0] ld, input logic [8:0] d,
                               input logic c, input logic z);
      vec_t v;
      v.op = op; v.dst = dst; v.s0 = s0; v.s1 = s1; v.ld = ld;
      v.exp_d = d; v.exp_c = c; v.exp_z = z;
      return v;
   endfunction

   // Monitor: one line per completed write-back.
   always @(negedge clk) begin
      if (rst && mon_en && (wr_en || done)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_writeback", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("WB cyc=%0d addr=%0d data=%03h c=%0b z=%0b", cyc, wr_addr, wr_data, carry, zero);
            check("wr_en",   int'(wr_en),   1);
            check("done",    int'(done),    1);
            check("wr_addr", int'(wr_addr), int'(e.addr));
            check("wr_data", int'(wr_data), int'(e.data));
            check("carry",   int'(carry),   int'(e.c));
            check("zero",    int'(zero),    int'(e.z));
            check("latency", cyc,           e.cyc);
         end
      end
   end

   // Presents v (valid high), waits at negedges for ready, returns at the
   // negedge inside READ with valid still high.
   task automatic send(input vec_t v, input bit push);
      int n = 0;
      instr_valid = 1'b1;
      instr       = {v.op, v.dst, v.s0, v.s1};
      ld_data     = v.ld;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("ready_timeout", 0, 1);
      if (push) begin
         exp_t e;
         e.addr = v.dst; e.data = v.exp_d; e.c = v.exp_c; e.z = v.exp_z;
         e.cyc  = cyc + 3;
         exp_q.push_back(e);
      end
      $display("ISSUE cyc=%0d op=%0d dst=%0d s0=%0d s1=%0d ld=%03h", cyc + 1, v.op, v.dst, v.s0, v.s1, v.ld);
      @(negedge clk);
   endtask

   task automatic send_one(input vec_t v);
      send(v, 1'b1);
      instr_valid = 1'b0;
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_ready"},   int'(instr_ready), 1);
      check({tag, "_wr_en"},   int'(wr_en),   0);
      check({tag, "_done"},    int'(done),    0);
      check({tag, "_wr_addr"}, int'(wr_addr), 0);
      check({tag, "_wr_data"}, int'(wr_data), 0);
      check({tag, "_rd0"},     int'(rd0_addr), 0);
      check({tag, "_rd1"},     int'(rd1_addr), 0);
      check({tag, "_carry"},   int'(carry),   0);
      check({tag, "_zero"},    int'(zero),    0);
   endtask

   vec_t seq_a[13];
   vec_t burst[4];

   initial begin
      int n;
      rst = 1'b0; instr_valid = 1'b0; instr = '0; ld_data = '0;

      // LOAD=7 SUB=1 ADD=0 AND=2 OR=3 XOR=4 NOT=5 SHL=6
      seq_a[0]  = mk(3'd7, 2'd1, 2'd0, 2'd0, 9'h0A5, 9'h0A5, 1'b0, 1'b0);
      seq_a[1]  = mk(3'd7, 2'd1, 2'd0, 2'd0, 9'h1FF, 9'h1FF, 1'b0, 1'b0);
      seq_a[2]  = mk(3'd7, 2'd2, 2'd0, 2'd0, 9'h001, 9'h001, 1'b0, 1'b0);
      seq_a[3]  = mk(3'd0, 2'd3, 2'd1, 2'd2, 9'h000, 9'h000, 1'b1, 1'b1);
      seq_a[4]  = mk(3'd7, 2'd1, 2'd0, 2'd0, 9'h005, 9'h005, 1'b0, 1'b0);
      seq_a[5]  = mk(3'd7, 2'd2, 2'd0, 2'd0, 9'h007, 9'h007, 1'b0, 1'b0);
      seq_a[6]  = mk(3'd1, 2'd0, 2'd1, 2'd2, 9'h000, 9'h1FE, 1'b1, 1'b0);
      seq_a[7]  = mk(3'd6, 2'd0, 2'd0, 2'd0, 9'h000, 9'h1FC, 1'b1, 1'b0);
      seq_a[8]  = mk(3'd2, 2'd1, 2'd1, 2'd2, 9'h000, 9'h005, 1'b0, 1'b0);
      seq_a[9]  = mk(3'd3, 2'd2, 2'd0, 2'd1, 9'h000, 9'h1FD, 1'b0, 1'b0);
      seq_a[10] = mk(3'd4, 2'd3, 2'd2, 2'd2, 9'h000, 9'h000, 1'b0, 1'b1);
      seq_a[11] = mk(3'd5, 2'd3, 2'd3, 2'd0, 9'h000, 9'h1FF, 1'b0, 1'b0);
      seq_a[12] = mk(3'd7, 2'd0, 2'd3, 2'd3, 9'h000, 9'h000, 1'b0, 1'b1);

      burst[0]  = mk(3'd7, 2'd1, 2'd0, 2'd0, 9'h0F0, 9'h0F0, 1'b0, 1'b0);
      burst[1]  = mk(3'd7, 2'd2, 2'd0, 2'd0, 9'h10F, 9'h10F, 1'b0, 1'b0);
      burst[2]  = mk(3'd0, 2'd3, 2'd1, 2'd2, 9'h000, 9'h1FF, 1'b0, 1'b0);
      burst[3]  = mk(3'd0, 2'd0, 2'd3, 2'd1, 9'h000, 9'h0EF, 1'b1, 1'b0);

      // Reset state
      repeat (2) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      // Reset during WRITE of a LOAD aborts immediately
      send(seq_a[0], 1'b0);
      instr_valid = 1'b0;
      n = 0;
      while (!wr_en && n < 10) begin @(negedge clk); n++; end
      check("abort_reach_write", int'(wr_en), 1);
      #2 rst = 1'b0;
      #1;
      check("abort_wr_en", int'(wr_en), 0);
      check("abort_done",  int'(done),  0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_idle_zero("post_abort");
      @(negedge clk);

      mon_en = 1'b1;

      // Directed sequence: LOAD, ADD overflow, SUB borrow, SHL, logic ops
      for (int i = 0; i < 13; i++) send_one(seq_a[i]);

      // Back-to-back with instr_valid held high; dependent ADDs
      for (int i = 0; i < 4; i++) send(burst[i], 1'b1);
      instr_valid = 1'b0;

      // Busy-time noise must not disturb the in-flight SUB r3 = r2 - r1
      send(mk(3'd1, 2'd3, 2'd2, 2'd1, 9'h000, 9'h01F, 1'b0, 1'b0), 1'b1);
      check("busy_ready_read", int'(instr_ready), 0);
      instr = 9'b111_00_11_10; ld_data = 9'h1AA; instr_valid = 1'b1;
      @(negedge clk);
      check("busy_ready_exec", int'(instr_ready), 0);
      instr = 9'b010_01_00_01; ld_data = 9'h055; instr_valid = 1'b0;
      #1 instr_valid = 1'b1;
      @(negedge clk);
      check("busy_ready_write", int'(instr_ready), 0);
      instr_valid = 1'b0;
      @(negedge clk);
      check("ready_after_write", int'(instr_ready), 1);

      // Drain
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
      check("queue_drained", exp_q.size(), 0);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
